// File: rtl/game_state_controller_if.sv
// Game sequencer bus: playfield events towards the sequencer, game status back out.
`timescale 1ns/1ps
interface game_state_controller_if;
    logic       tick;
    logic       start_btn;
    logic       pellet_eaten;
    logic       ghost_hit;
    logic [2:0] game_state;
    logic       move_en;
    logic       pm_respawn;
    logic       pellet_refill;
    logic [2:0] lives;
    logic [3:0] level;
    logic [6:0] pel_left;
    logic       blink;

    // Master drives the playfield events and observes the game status.
    modport master (
        output tick, start_btn, pellet_eaten, ghost_hit,
        input  game_state, move_en, pm_respawn, pellet_refill, lives, level, pel_left, blink
    );

    // Slave is the sequencer itself.
    modport slave (
        input  tick, start_btn, pellet_eaten, ghost_hit,
        output game_state, move_en, pm_respawn, pellet_refill, lives, level, pel_left, blink
    );
endinterface

// File: rtl/game_state_controller.sv
// Top-level Pac-Man game sequencer: gates movement, issues respawn/refill pulses and keeps
// lives, level and pellets-left. All outputs are registered.
`timescale 1ns/1ps
module game_state_controller #(
    parameter int unsigned NUM_PELLETS = 64,
    parameter int unsigned START_LIVES = 3,
    parameter int unsigned READY_TICKS = 120,
    parameter int unsigned DEATH_TICKS = 90,
    parameter int unsigned CLEAR_TICKS = 120,
    parameter int unsigned BLINK_SHIFT = 4
) (
    input logic                    clk,
    input logic                    rst,
    game_state_controller_if.slave bus
);

    localparam int unsigned MaxRd    = (READY_TICKS > DEATH_TICKS) ? READY_TICKS : DEATH_TICKS;
    localparam int unsigned MaxTicks = (MaxRd > CLEAR_TICKS) ? MaxRd : CLEAR_TICKS;
    localparam int unsigned CntW     = $clog2(MaxTicks + 1);
    // Timer must also be wide enough to carry the blink bit.
    localparam int unsigned TimerW   = (CntW > BLINK_SHIFT + 1) ? CntW : BLINK_SHIFT + 1;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StReady = 3'd1,
        StPlay  = 3'd2,
        StDying = 3'd3,
        StClear = 3'd4,
        StOver  = 3'd5
    } state_e;

    state_e              state_q, state_d;
    logic [TimerW-1:0]   timer_q, timer_d;
    logic                start_q;
    logic [2:0]          lives_q, lives_d;
    logic [3:0]          level_q, level_d;
    logic [6:0]          pel_left_q, pel_left_d;
    logic                move_en_q, move_en_d;
    logic                respawn_q, respawn_d;
    logic                refill_q, refill_d;
    logic                blink_q, blink_d;
    logic                start_edge;
    logic                timed;

    assign start_edge = bus.start_btn & ~start_q;
    // OVER keeps counting so the blink keeps running while waiting for a new game.
    assign timed = (state_q == StReady) || (state_q == StDying) ||
                   (state_q == StClear) || (state_q == StOver);

    // Next-state, counters and registered-output values.
    always_comb begin
        state_d    = state_q;
        lives_d    = lives_q;
        level_d    = level_q;
        pel_left_d = pel_left_q;
        respawn_d  = 1'b0;
        refill_d   = 1'b0;

        unique case (state_q)
            StIdle, StOver: begin
                if (start_edge) begin
                    state_d    = StReady;
                    lives_d    = 3'(START_LIVES);
                    level_d    = 4'd1;
                    pel_left_d = 7'(NUM_PELLETS);
                    respawn_d  = 1'b1;
                    refill_d   = 1'b1;
                end
            end
            StReady: begin
                if (bus.tick && timer_q == TimerW'(READY_TICKS - 1)) begin
                    state_d = StPlay;
                end
            end
            StPlay: begin
                // Clearing the level takes precedence over a simultaneous ghost hit.
                if (bus.pellet_eaten && pel_left_q == 7'd1) begin
                    state_d    = StClear;
                    pel_left_d = 7'd0;
                end else begin
                    if (bus.pellet_eaten && pel_left_q != 7'd0) begin
                        pel_left_d = pel_left_q - 7'd1;
                    end
                    if (bus.ghost_hit) begin
                        state_d = StDying;
                        if (lives_q != 3'd0) begin
                            lives_d = lives_q - 3'd1;
                        end
                    end
                end
            end
            StDying: begin
                if (bus.tick && timer_q == TimerW'(DEATH_TICKS - 1)) begin
                    if (lives_q != 3'd0) begin
                        state_d   = StReady;
                        respawn_d = 1'b1;
                    end else begin
                        state_d = StOver;
                    end
                end
            end
            StClear: begin
                if (bus.tick && timer_q == TimerW'(CLEAR_TICKS - 1)) begin
                    state_d    = StReady;
                    level_d    = (level_q == 4'd15) ? 4'd15 : level_q + 4'd1;
                    pel_left_d = 7'(NUM_PELLETS);
                    respawn_d  = 1'b1;
                    refill_d   = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (state_d != state_q) begin
            timer_d = '0;
        end else if (bus.tick && timed) begin
            timer_d = timer_q + 1'b1;
        end else begin
            timer_d = timer_q;
        end

        move_en_d = (state_d == StPlay);
        blink_d   = (state_d inside {StReady, StClear, StOver}) ? ~timer_d[BLINK_SHIFT] : 1'b1;
    end

    // State, counters and output registers; reset aborts any game in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            timer_q    <= '0;
            start_q    <= 1'b0;
            lives_q    <= 3'd0;
            level_q    <= 4'd0;
            pel_left_q <= 7'd0;
            move_en_q  <= 1'b0;
            respawn_q  <= 1'b0;
            refill_q   <= 1'b0;
            blink_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            start_q    <= bus.start_btn;
            lives_q    <= lives_d;
            level_q    <= level_d;
            pel_left_q <= pel_left_d;
            move_en_q  <= move_en_d;
            respawn_q  <= respawn_d;
            refill_q   <= refill_d;
            blink_q    <= blink_d;
        end
    end

    assign bus.game_state    = state_q;
    assign bus.move_en       = move_en_q;
    assign bus.pm_respawn    = respawn_q;
    assign bus.pellet_refill = refill_q;
    assign bus.lives         = lives_q;
    assign bus.level         = level_q;
    assign bus.pel_left      = pel_left_q;
    assign bus.blink         = blink_q;

endmodule

// File: tb/tb_game_state_controller.sv
// Randomized bench for game_state_controller against a tick-counting game model.
`timescale 1ns/1ps
module tb_game_state_controller;

    localparam int NUM_PELLETS = 64;
    localparam int START_LIVES = 3;
    localparam int READY_TICKS = 120;
    localparam int DEATH_TICKS = 90;
    localparam int CLEAR_TICKS = 120;
    localparam int BLINK_SHIFT = 4;

    localparam int S_IDLE  = 0;
    localparam int S_READY = 1;
    localparam int S_PLAY  = 2;
    localparam int S_DYING = 3;
    localparam int S_CLEAR = 4;
    localparam int S_OVER  = 5;

    logic clk;
    logic rst;
    game_state_controller_if bus ();

    game_state_controller dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_fail;
    int n_resp;
    int n_refill;

    // Model of the game: state, ticks spent in the current state, counters, last-cycle pulses.
    int m_state, m_ticks, m_lives, m_level, m_pel;
    bit m_prev_start, m_resp, m_refill;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit rnd(input int pct);
        return $urandom_range(99, 0) < pct;
    endfunction

    task automatic model_reset();
        m_state = S_IDLE; m_ticks = 0; m_lives = 0; m_level = 0; m_pel = 0;
        m_prev_start = 0; m_resp = 0; m_refill = 0;
    endtask

    task automatic model_new_game();
        m_lives = START_LIVES; m_level = 1; m_pel = NUM_PELLETS;
        m_resp = 1; m_refill = 1;
    endtask

    task automatic model_step(input bit t, input bit s, input bit p, input bit g);
        bit edge_seen;
        int nxt;
        edge_seen = s && !m_prev_start;
        m_prev_start = s;
        m_resp = 0;
        m_refill = 0;
        nxt = m_state;
        if (t) m_ticks++;
        case (m_state)
            S_IDLE, S_OVER: if (edge_seen) begin nxt = S_READY; model_new_game(); end
            S_READY: if (m_ticks == READY_TICKS) nxt = S_PLAY;
            S_PLAY: begin
                if (p && m_pel == 1) begin
                    nxt = S_CLEAR;
                    m_pel = 0;
                end else begin
                    if (p && m_pel > 0) m_pel--;
                    if (g) begin
                        nxt = S_DYING;
                        if (m_lives > 0) m_lives--;
                    end
                end
            end
            S_DYING: if (m_ticks == DEATH_TICKS) begin
                if (m_lives > 0) begin nxt = S_READY; m_resp = 1; end
                else nxt = S_OVER;
            end
            S_CLEAR: if (m_ticks == CLEAR_TICKS) begin
                nxt = S_READY;
                m_level = (m_level >= 15) ? 15 : m_level + 1;
                m_pel = NUM_PELLETS;
                m_resp = 1;
                m_refill = 1;
            end
            default: nxt = S_IDLE;
        endcase
        if (nxt != m_state) m_ticks = 0;
        m_state = nxt;
    endtask

    function automatic int exp_blink();
        if (m_state == S_READY || m_state == S_CLEAR || m_state == S_OVER)
            return ((m_ticks >> BLINK_SHIFT) & 1) == 0 ? 1 : 0;
        return 1;
    endfunction

    task automatic compare_all();
        check_eq("state", int'(bus.game_state), m_state);
        check_eq("move_en", int'(bus.move_en), (m_state == S_PLAY) ? 1 : 0);
        check_eq("pm_respawn", int'(bus.pm_respawn), int'(m_resp));
        check_eq("pellet_refill", int'(bus.pellet_refill), int'(m_refill));
        check_eq("lives", int'(bus.lives), m_lives);
        check_eq("level", int'(bus.level), m_level);
        check_eq("pel_left", int'(bus.pel_left), m_pel);
        check_eq("blink", int'(bus.blink), exp_blink());
    endtask

    task automatic run_cycle(input bit t, input bit s, input bit p, input bit g);
        @(negedge clk);
        bus.tick = t; bus.start_btn = s; bus.pellet_eaten = p; bus.ghost_hit = g;
        @(posedge clk);
        model_step(t, s, p, g);
        #1;
        compare_all();
        if (bus.pm_respawn) n_resp++;
        if (bus.pellet_refill) n_refill++;
    endtask

    // Random cycles until the model reaches target; an exhausted budget shows up as a failure.
    task automatic run_until(input int target, input int max_cyc, input int p_tick,
                             input int p_pel, input int p_ghost, input int p_start);
        int n = 0;
        while (m_state != target && n < max_cyc) begin
            run_cycle(rnd(p_tick), rnd(p_start), rnd(p_pel), rnd(p_ghost));
            n++;
        end
        check_eq("reach_state", int'(bus.game_state), target);
    endtask

    initial begin
        int saved_pel;
        n_checks = 0; n_fail = 0; n_resp = 0; n_refill = 0;
        bus.tick = 0; bus.start_btn = 0; bus.pellet_eaten = 0; bus.ghost_hit = 0;

        // Reset state.
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        rst = 1'b0;

        // IDLE ignores playfield traffic.
        repeat (20) run_cycle(rnd(50), 1'b0, rnd(50), rnd(50));
        check_eq("idle_hold", int'(bus.game_state), S_IDLE);

        // New game.
        n_resp = 0; n_refill = 0;
        run_cycle(1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("start_state", int'(bus.game_state), S_READY);
        check_eq("start_lives", int'(bus.lives), 3);
        check_eq("start_level", int'(bus.level), 1);
        check_eq("start_pel", int'(bus.pel_left), 64);
        check_eq("start_pulses", n_resp + n_refill, 2);
        run_until(S_PLAY, 2000, 50, 50, 30, 50);
        check_eq("play_move_en", int'(bus.move_en), 1);

        // Eat the whole field.
        run_until(S_CLEAR, 2000, 50, 60, 0, 50);
        check_eq("clear_pel", int'(bus.pel_left), 0);
        check_eq("clear_move_en", int'(bus.move_en), 0);
        check_eq("clear_lives", int'(bus.lives), 3);
        n_resp = 0; n_refill = 0;
        run_until(S_READY, 2000, 50, 50, 50, 50);
        check_eq("lvl2_level", int'(bus.level), 2);
        check_eq("lvl2_pel", int'(bus.pel_left), 64);
        check_eq("lvl2_refills", n_refill, 1);

        // Death keeps the remaining pellets.
        run_until(S_PLAY, 2000, 50, 0, 0, 50);
        repeat (5) run_cycle(rnd(50), 1'b0, 1'b1, 1'b0);
        saved_pel = m_pel;
        run_cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("hit_state", int'(bus.game_state), S_DYING);
        check_eq("hit_lives", int'(bus.lives), 2);
        n_resp = 0; n_refill = 0;
        run_until(S_READY, 2000, 50, 50, 50, 50);
        check_eq("death_refills", n_refill, 0);
        check_eq("death_respawns", n_resp, 1);
        check_eq("death_pel", int'(bus.pel_left), saved_pel);

        // Last pellet and ghost in the same cycle: level clears, no life lost.
        run_until(S_PLAY, 2000, 50, 0, 0, 0);
        begin
            int n = 0;
            while (m_pel != 1 && n < 200) begin
                run_cycle(rnd(50), rnd(50), 1'b1, 1'b0);
                n++;
            end
        end
        check_eq("last_pel", int'(bus.pel_left), 1);
        run_cycle(1'b0, 1'b0, 1'b1, 1'b1);
        check_eq("tie_state", int'(bus.game_state), S_CLEAR);
        check_eq("tie_lives", int'(bus.lives), 2);
        repeat (10) run_cycle(1'b0, rnd(50), 1'b0, 1'b0);
        check_eq("clear_start_ignored", int'(bus.game_state), S_CLEAR);
        run_until(S_READY, 2000, 50, 50, 50, 50);
        run_until(S_PLAY, 2000, 50, 0, 0, 50);
        check_eq("pre_rst_level", int'(bus.level), 3);

        // Reset mid-game.
        bus.tick = 0; bus.start_btn = 0; bus.pellet_eaten = 0; bus.ghost_hit = 0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        check_eq("rst_state", int'(bus.game_state), S_IDLE);
        check_eq("rst_lives", int'(bus.lives), 0);
        check_eq("rst_level", int'(bus.level), 0);
        check_eq("rst_move_en", int'(bus.move_en), 0);
        rst = 1'b0;

        // Lose every life, then restart from OVER.
        run_cycle(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            run_until(S_PLAY, 2000, 50, 0, 0, 0);
            run_cycle(1'b0, 1'b0, 1'b0, 1'b1);
            run_until((m_lives != 0) ? S_READY : S_OVER, 2000, 50, 50, 50, 0);
        end
        check_eq("over_state", int'(bus.game_state), S_OVER);
        check_eq("over_lives", int'(bus.lives), 0);
        repeat (300) run_cycle(1'b1, 1'b0, rnd(50), rnd(50));
        run_cycle(1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("restart_state", int'(bus.game_state), S_READY);
        check_eq("restart_lives", int'(bus.lives), 3);

        // Push the level counter into saturation.
        for (int i = 0; i < 15; i++) begin
            run_until(S_PLAY, 2000, 100, 0, 0, 0);
            run_until(S_CLEAR, 2000, 100, 90, 0, 0);
            run_until(S_READY, 2000, 100, 0, 0, 0);
        end
        check_eq("level_sat", int'(bus.level), 15);

        // Free-running soak.
        repeat (3000) run_cycle(rnd(50), rnd(10), rnd(30), rnd(3));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
